// File: rtl/dut_run_host.sv
// Host sequencer: load program, pulse start, time the run, stream data memory back.
// Latency: outputs decoded combinationally from registered state/index; dut_start registered.
// Backpressure: ld_valid gaps stall LOAD; rb_ready low holds dm_addr/rb_data stable in READBACK.
//
// Ports:
//   CLK, reset                    clock (posedge), async active-high reset
//   go, prog_len, rd_base, rd_len session request and its parameters (latched in IDLE)
//   ld_valid/ld_data/ld_ready     program stream into instruction memory
//   im_we/im_addr/im_wdata        instruction-memory write port
//   dut_start / dut_halt          processor start/halt handshake
//   dm_own/dm_addr/dm_rdata       data-memory read port (combinational read data)
//   rb_valid/rb_data/rb_ready     readback stream
//   busy, done, timed_out, cycles session status
module dut_run_host #(
    parameter int          PC_W         = 10,
    parameter int          INSTR_W      = 9,
    parameter int          ADDR_W       = 8,
    parameter int          DATA_W       = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               go,
    input  logic [PC_W-1:0]    prog_len,
    input  logic [ADDR_W-1:0]  rd_base,
    input  logic [ADDR_W:0]    rd_len,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    output logic               im_we,
    output logic [PC_W-1:0]    im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic               dut_start,
    input  logic               dut_halt,
    output logic               dm_own,
    output logic [ADDR_W-1:0]  dm_addr,
    input  logic [DATA_W-1:0]  dm_rdata,
    output logic               rb_valid,
    output logic [DATA_W-1:0]  rb_data,
    input  logic               rb_ready,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [15:0]        cycles
);

    // One index serves the load beat count, the start-pulse timer and the
    // readback beat count; it must hold prog_len-1 and rd_len-1 (up to 255).
    localparam int IDX_W = (PC_W > ADDR_W + 1) ? PC_W : ADDR_W + 1;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] START_LAST = IDX_W'(START_CYCLES - 1);
    localparam logic [15:0]      TMO_LAST   = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_READBACK,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    prog_len_q, prog_len_d;
    logic [IDX_W-1:0]    rd_len_q, rd_len_d;
    logic [ADDR_W-1:0]   rd_base_q, rd_base_d;
    logic [15:0]         cycles_q, cycles_d;
    logic                timed_out_q, timed_out_d;
    logic                dut_start_q, dut_start_d;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            prog_len_q  <= '0;
            rd_len_q    <= '0;
            rd_base_q   <= '0;
            cycles_q    <= '0;
            timed_out_q <= 1'b0;
            dut_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            prog_len_q  <= prog_len_d;
            rd_len_q    <= rd_len_d;
            rd_base_q   <= rd_base_d;
            cycles_q    <= cycles_d;
            timed_out_q <= timed_out_d;
            dut_start_q <= dut_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        prog_len_d  = prog_len_q;
        rd_len_d    = rd_len_q;
        rd_base_d   = rd_base_q;
        cycles_d    = cycles_q;
        timed_out_d = timed_out_q;

        ld_ready = 1'b0;
        im_we    = 1'b0;
        im_addr  = '0;
        im_wdata = '0;
        dm_own   = 1'b0;
        dm_addr  = '0;
        rb_valid = 1'b0;
        rb_data  = '0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    prog_len_d  = IDX_W'(prog_len);
                    rd_len_d    = IDX_W'(rd_len);
                    rd_base_d   = rd_base;
                    cycles_d    = '0;
                    timed_out_d = 1'b0;
                    idx_d       = '0;
                    state_d     = (prog_len != '0) ? S_LOAD : S_START;
                end
            end

            S_LOAD: begin
                ld_ready = 1'b1;
                im_we    = ld_valid;
                im_addr  = idx_q[PC_W-1:0];
                im_wdata = ld_data;
                if (ld_valid) begin
                    if (idx_q == prog_len_q - IDX_ONE) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            // The index times the start pulse so it is zero again on entry to RUN
            // and therefore ready as the readback offset.
            S_START: begin
                if (idx_q == START_LAST) begin
                    idx_d   = '0;
                    state_d = S_RUN;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end

            // Halt wins over timeout on the same cycle; the timeout cycle itself
            // is a counted (halt=0) cycle.
            S_RUN: begin
                if (dut_halt) begin
                    state_d = (rd_len_q == '0) ? S_DONE : S_READBACK;
                end else if (cycles_q == TMO_LAST) begin
                    cycles_d    = cycles_q + 16'd1;
                    timed_out_d = 1'b1;
                    state_d     = (rd_len_q == '0) ? S_DONE : S_READBACK;
                end else begin
                    cycles_d = cycles_q + 16'd1;
                end
            end

            // Address wraps naturally in ADDR_W bits.
            S_READBACK: begin
                dm_own   = 1'b1;
                dm_addr  = rd_base_q + idx_q[ADDR_W-1:0];
                rb_valid = 1'b1;
                rb_data  = dm_rdata;
                if (rb_ready) begin
                    if (idx_q == rd_len_q - IDX_ONE) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered start strobe: high exactly while the next state is START.
        dut_start_d = (state_d == S_START);
    end

    assign dut_start = dut_start_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign timed_out = timed_out_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_dut_run_host.sv
// Self-checking bench for dut_run_host: random sessions against a behavioural session model.
// Latency: one negedge-sampled observation per clock; expectations derived from session parameters.
// Backpressure: random ld_valid gaps and rb_ready throttling applied every session.
module tb_dut_run_host;

    localparam int TMO      = 8;
    localparam int START_CY = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        go = 1'b0;
    logic [9:0]  prog_len = '0;
    logic [7:0]  rd_base = '0;
    logic [8:0]  rd_len = '0;
    logic        ld_valid = 1'b0;
    logic [8:0]  ld_data = '0;
    logic        ld_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [8:0]  im_wdata;
    logic        dut_start;
    logic        dut_halt = 1'b0;
    logic        dm_own;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_rdata;
    logic        rb_valid;
    logic [7:0]  rb_data;
    logic        rb_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        timed_out;
    logic [15:0] cycles;

    logic [8:0]  prog_mem [1024];
    logic [7:0]  dm_mem   [256];

    int n_checks = 0;
    int n_errors = 0;

    assign dm_rdata = dm_mem[dm_addr];

    always #5 CLK = ~CLK;

    dut_run_host #(
        .PC_W(10), .INSTR_W(9), .ADDR_W(8), .DATA_W(8),
        .START_CYCLES(START_CY), .TIMEOUT(16'(TMO))
    ) dut (
        .CLK(CLK), .reset(reset), .go(go), .prog_len(prog_len), .rd_base(rd_base),
        .rd_len(rd_len), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .dut_start(dut_start),
        .dut_halt(dut_halt), .dm_own(dm_own), .dm_addr(dm_addr), .dm_rdata(dm_rdata),
        .rb_valid(rb_valid), .rb_data(rb_data), .rb_ready(rb_ready), .busy(busy),
        .done(done), .timed_out(timed_out), .cycles(cycles)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{ld_ready, im_we, im_addr, im_wdata, dut_start, dm_own, dm_addr,
                 rb_valid, rb_data, busy, done, timed_out, cycles};
    endfunction

    // One session. halt_at: RUN cycle (1-based) on which halt rises, 0 = never.
    // gp: cycle index at which go is re-pulsed with junk parameters, -1 = none.
    task automatic session(input int n, input logic [7:0] base, input int l, input int halt_at,
                           input int vld_pct, input int rdy_pct, input int gp);
        int t, ld_i, wr_cnt, rb_cnt, rbv_cnt, st_cnt, ldr_cnt, run_cyc, t_done;
        int hrun, exp_cyc;
        bit exp_to, start_seen, fin;
        logic [7:0] exp_a;
        exp_to  = (halt_at == 0) || (halt_at > TMO);
        exp_cyc = exp_to ? TMO : halt_at - 1;
        hrun    = exp_to ? TMO : halt_at;
        t = 0; ld_i = 0; wr_cnt = 0; rb_cnt = 0; rbv_cnt = 0; st_cnt = 0; ldr_cnt = 0;
        run_cyc = 0; t_done = -1; start_seen = 0; fin = 0;
        while (!fin && t < 3000) begin
            @(negedge CLK);
            if (t == 0) begin
                go = 1'b1; prog_len = 10'(n); rd_base = base; rd_len = 9'(l);
            end else if (t == gp) begin
                go = 1'b1; prog_len = 10'($urandom); rd_base = 8'($urandom);
                rd_len = 9'($urandom_range(1, 256));
            end else begin
                go = 1'b0;
            end
            if (dut_start) start_seen = 1;
            else if (start_seen) run_cyc++;
            if (start_seen && !dut_start) dut_halt = (halt_at != 0) && (run_cyc >= halt_at);
            else dut_halt = 1'($urandom_range(0, 1));
            ld_valid = (ld_i < n) && ($urandom_range(1, 100) <= vld_pct);
            ld_data  = ld_valid ? prog_mem[ld_i] : 9'($urandom);
            rb_ready = ($urandom_range(1, 100) <= rdy_pct);
            #1;
            if (t == 1) begin
                check("clr_cycles", 32'(cycles), 0);
                check("clr_timed_out", 32'(timed_out), 0);
            end
            if (dut_start) st_cnt++;
            if (ld_ready) ldr_cnt++;
            if (im_we) begin
                check("im_addr", 32'(im_addr), 32'(wr_cnt));
                check("im_wdata", 32'(im_wdata), 32'(prog_mem[wr_cnt % 1024]));
                wr_cnt++;
            end
            if (ld_valid && ld_ready) ld_i++;
            if (rb_valid) begin
                rbv_cnt++;
                exp_a = base + 8'(rb_cnt);
                check("dm_addr", 32'(dm_addr), 32'(exp_a));
                check("rb_data", 32'(rb_data), 32'(dm_mem[exp_a]));
                check("dm_own", 32'(dm_own), 1);
                if (rb_ready) rb_cnt++;
            end
            if (done) begin
                fin = 1; t_done = t;
                check("cycles", 32'(cycles), 32'(exp_cyc));
                check("timed_out", 32'(timed_out), 32'(exp_to));
            end
            t++;
        end
        check("session_done", 32'(fin), 1);
        check("load_beats", 32'(wr_cnt), 32'(n));
        check("start_len", 32'(st_cnt), START_CY);
        check("rb_beats", 32'(rb_cnt), 32'(l));
        if (n == 0) check("ld_ready_idle", 32'(ldr_cnt), 0);
        if (l == 0) check("rb_valid_idle", 32'(rbv_cnt), 0);
        if (vld_pct == 100 && l == 0) check("latency", 32'(t_done), 32'(n + 1 + START_CY + hrun));
        @(negedge CLK);
        go = 1'b0; ld_valid = 1'b0; dut_halt = 1'b0;
        #1;
        check("done_pulse", 32'(done), 0);
        check("idle_after", 32'(busy), 0);
        check("cycles_hold", 32'(cycles), 32'(exp_cyc));
        check("to_hold", 32'(timed_out), 32'(exp_to));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, l, ha, vp;
        for (int i = 0; i < 256; i++) dm_mem[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) prog_mem[i] = 9'($urandom);

        // Reset state.
        reset = 1'b1;
        ld_valid = 1'b1;
        #1;
        check("rst_outs", 32'(any_out()), 0);
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        ld_valid = 1'b0;
        #1;
        check("rst_idle", 32'(busy), 0);

        // Gapped load of three words, halt on 5th RUN cycle, no readback.
        prog_mem[0] = 9'h1A5; prog_mem[1] = 9'h000; prog_mem[2] = 9'h1FF;
        session(3, 8'h10, 0, 5, 50, 100, -1);

        // Timeout with readback still performed.
        session(4, 8'h40, 3, 0, 100, 70, -1);

        // Readback wrap with back-pressure.
        session(2, 8'hFE, 4, 2, 100, 50, -1);

        // Zero lengths.
        session(0, 8'h00, 0, 3, 100, 100, -1);

        // Halt on exactly the last pre-timeout cycle: halt wins.
        session(1, 8'h00, 0, TMO, 100, 100, -1);

        // Full 256-byte readback wrapping through 0x00.
        session(0, 8'h80, 256, 1, 100, 80, -1);

        // go while busy (during RUN) is ignored.
        session(5, 8'h33, 2, 3, 100, 100, 8);

        // Random sessions.
        for (int k = 0; k < 10; k++) begin
            n  = $urandom_range(0, 20);
            for (int i = 0; i < n; i++) prog_mem[i] = 9'($urandom);
            l  = (k % 3 == 0) ? 0 : $urandom_range(0, 20);
            ha = $urandom_range(0, 10);
            vp = (k % 3 == 0) ? 100 : $urandom_range(30, 100);
            session(n, 8'($urandom), l, ha, vp, $urandom_range(30, 100), (k == 4) ? 5 : -1);
        end

        // Reset in the middle of READBACK.
        @(negedge CLK);
        go = 1'b1; prog_len = '0; rd_base = 8'h20; rd_len = 9'd10; dut_halt = 1'b0; rb_ready = 1'b0;
        @(negedge CLK);
        go = 1'b0;
        repeat (4) @(negedge CLK);
        dut_halt = 1'b1;
        @(negedge CLK);
        #1;
        check("pre_rst_rb_valid", 32'(rb_valid), 1);
        check("pre_rst_cycles", 32'(cycles), 2);
        reset = 1'b1;
        ld_valid = 1'b1;
        #1;
        check("midrst_outs", 32'(any_out()), 0);
        @(negedge CLK);
        reset = 1'b0;
        ld_valid = 1'b0;
        dut_halt = 1'b0;
        #1;
        check("midrst_idle", 32'(busy), 0);
        check("midrst_no_done", 32'(done), 0);

        // Recovery after reset.
        session(2, 8'hF0, 5, 4, 80, 60, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dut_run_host.md
# dut_run_host

Host-side sequencer for the 9-bit-instruction basic processor: drives the other end of the processor's start/halt handshake and memory-load interfaces. It streams a program into instruction memory, pulses `dut_start`, times the run until `dut_halt`, then reads a window of data memory back out on a valid/ready stream. It sits beside the processor top level in the test/FPGA wrapper. The wrapper muxes the instruction-memory write port and the data-memory address onto the processor's memories.

## Interface
- `PC_W`, 10: instruction-memory address width
- `INSTR_W`, 9: instruction word width
- `ADDR_W`, 8: data-memory address width
- `DATA_W`, 8: data-memory word width
- `START_CYCLES`, 2: cycles `dut_start` is held high (≥1)
- `TIMEOUT`, 16'hFFFF: run-cycle limit

Ports:
- `CLK` in 1: clock, posedge
- `reset` in 1: asynchronous, active-high reset
- `go` in 1: begin session; sampled only in IDLE
- `prog_len` in PC_W: instructions to load; latched on go
- `rd_base` in ADDR_W: first data address to read back; latched on go
- `rd_len` in ADDR_W+1: bytes to read back (0..256); latched on go
- `ld_valid` in 1, `ld_data` in INSTR_W: program stream
- `ld_ready` out 1: program stream ready
- `im_we` out 1, `im_addr` out PC_W, `im_wdata` out INSTR_W: instruction-memory write port
- `dut_start` out 1: to processor start/init
- `dut_halt` in 1: from processor halt
- `dm_own` out 1: host owns data-memory address mux
- `dm_addr` out ADDR_W: data-memory address
- `dm_rdata` in DATA_W: combinational read data
- `rb_valid` out 1, `rb_data` out DATA_W: readback stream
- `rb_ready` in 1: readback stream ready
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at session end
- `timed_out` out 1: last run hit TIMEOUT
- `cycles` out 16: run-cycle count of last run

## Operation
- States: IDLE, LOAD, START, RUN, READBACK, DONE.
- IDLE: on `go`=1, latch parameters and clear `cycles`, `timed_out`, and the internal index.
  - Next state is LOAD if `prog_len`≠0, else START.
- LOAD: `ld_ready`=1. `im_we`=`ld_valid`, `im_addr`=index, `im_wdata`=`ld_data` (combinational pass-through).
  - Each beat advances the index.
  - After beat `prog_len`-1 is accepted, clear the index and go to START.
- START: `dut_start`=1 for exactly START_CYCLES cycles, then RUN.
- RUN: `dut_start`=0.
  - If `dut_halt`=1, go to READBACK, or to DONE if `rd_len`=0.
  - Else, if `cycles`=TIMEOUT-1, increment `cycles`, set `timed_out`=1 and leave the same way as on halt.
  - Else increment `cycles`.
  - `dut_halt` is ignored outside RUN.
- READBACK: `dm_own`=1, `dm_addr`=`rd_base`+index (mod 2^ADDR_W, wraps 0xFF→0x00), `rb_valid`=1, `rb_data`=`dm_rdata`.
  - On `rb_valid`&`rb_ready`, advance the index.
  - After beat `rd_len`-1, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `cycles` and `timed_out` hold from DONE until the next accepted `go`.
- `go` while `busy` has no effect.

## Timing
- Reset values: state IDLE; all outputs 0 (`dut_start`=0, `dm_own`=0, `rb_valid`=0, `cycles`=0).
- Reset mid-session returns to IDLE immediately. No done pulse, counters cleared.
- All state, counters and `dut_start` are registered. `im_*`, `ld_ready`, `rb_*`, `dm_*` are decoded from state/index, with no extra latency.
- Load throughput is 1 beat/cycle. A session with `prog_len`=N and `rd_len`=0 and halt on RUN cycle h is: 1 (IDLE go) + N + START_CYCLES + h + 1 (DONE) cycles to `done`.
- `cycles` equals the number of RUN cycles with `dut_halt`=0 sampled. Halt on the first RUN cycle gives `cycles`=0.
- Readback data is valid the cycle `dm_addr` is presented. Back-pressure on `rb_ready` holds `dm_addr`/`rb_data` stable.

## Test plan
- Load stream: `prog_len`=3, words 0x1A5,0x000,0x1FF with `ld_valid` gapped → `im_we` pulses at `im_addr` 0,1,2 with matching data. Then `dut_start` high exactly 2 cycles.
- Run timing: `dut_halt` asserted on the 5th RUN cycle → `cycles`=4, `timed_out`=0, `done` pulses one cycle.
- Timeout: `TIMEOUT`=8 and `dut_halt` held 0 → `cycles`=8, `timed_out`=1, readback still performed.
- Readback wrap with back-pressure: `rd_base`=0xFE, `rd_len`=4, `rb_ready` toggling → `dm_addr` 0xFE,0xFF,0x00,0x01 in order, each held while `rb_ready`=0, 4 beats total.
- Zero lengths: `prog_len`=0, `rd_len`=0 → IDLE→START→RUN→DONE; `ld_ready` and `rb_valid` never assert.
- Reset mid-READBACK and `go` while busy: reset → all outputs 0 in the same cycle, IDLE; `go` pulsed during RUN → ignored, session unchanged.
